// File: rtl/alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_pkg
//   Shared constants and types for the ALU issue controller:
//   - RV32I opcodes handled by this unit (register, immediate, LUI)
//   - ALU func3 operation codes understood by the external ALU
//   - FSM state encoding (plain localparams)
//   - dec_t: decoded instruction bundle handed from decoder to controller
// ---------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_PASS = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_WB   = 2'b10;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  func3;
        logic        subsra;
        logic [4:0]  rd;
        logic        illegal;
    } dec_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SR);
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// ---------------------------------------------------------------------------
// alu_issue_decode
//   Combinational decode of an RV32I R-type, I-type ALU or LUI instruction
//   into ALU operands and controls.
// Ports
//   instr    in  32  instruction word
//   rs1_val  in  32  rs1 register value
//   rs2_val  in  32  rs2 register value
//   dec      out     {op1, op2, func3, subsra, rd, illegal}
// ---------------------------------------------------------------------------
module alu_issue_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7b5;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign f7b5   = instr[30];

    always_comb begin
        // NOTE: every field gets a default before the case so that no path
        // leaves a field unassigned, which would infer a latch.
        dec         = '0;
        dec.rd      = instr[11:7];
        dec.func3   = f3;

        case (opcode)
            OP_R: begin
                dec.op1     = rs1_val;
                dec.op2     = rs2_val;
                // Only add/sub and the right shifts have an alternate form.
                dec.subsra  = f7b5 && ((f3 == F3_ADD) || (f3 == F3_SR));
                dec.illegal = (f3 == F3_PASS)
                           || ((f7 != F7_BASE) && (f7 != F7_ALT))
                           || (f7b5 && (f3 != F3_ADD) && (f3 != F3_SR));
            end
            OP_I: begin
                dec.op1     = rs1_val;
                dec.op2     = {{20{instr[31]}}, instr[31:20]};
                // instr[30] is an ordinary immediate bit except for srai;
                // addi never subtracts.
                dec.subsra  = f7b5 && (f3 == F3_SR);
                dec.illegal = (f3 == F3_PASS)
                           || ((f3 == F3_SLL) && (f7 != F7_BASE))
                           || ((f3 == F3_SR) && (f7 != F7_BASE) && (f7 != F7_ALT));
            end
            OP_LUI: begin
                dec.op1     = 32'd0;
                dec.op2     = {instr[31:12], 12'b0};
                dec.func3   = F3_PASS;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        // The ALU takes the full op2 as shift amount; keep only shamt.
        if (is_shift(dec.func3)) begin
            dec.op2 = {27'b0, dec.op2[4:0]};
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Initiator side of the single-cycle ALU interface. Accepts a decoded
//   register bundle, drives registered ALU operands/controls for one EXEC
//   cycle, captures ALUresult and offers it to writeback.
//   Sequence: IDLE -(accept, legal)-> EXEC -> WB -(handshake)-> IDLE
//             IDLE -(accept, illegal)-> WB (wb_err=1, wb_data=0)
// Ports
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             instruction bundle handshake
//   in_instr, in_rs1_val, in_rs2_val   bundle contents
//   ALUop1, ALUop2, ALUfunc3, ALUsubsra  registered ALU inputs
//   ALUresult                     combinational ALU result
//   wb_valid/wb_ready             writeback handshake
//   wb_rd, wb_data, wb_err        writeback payload
//   retired                       wrapping count of wb handshakes
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1_val,
    input  logic [31:0]      in_rs2_val,
    output logic [31:0]      ALUop1,
    output logic [31:0]      ALUop2,
    output logic [2:0]       ALUfunc3,
    output logic             ALUsubsra,
    input  logic [31:0]      ALUresult,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             wb_err,
    output logic [CNT_W-1:0] retired
);

    logic [1:0] state;
    dec_t       dec;
    logic       accept;
    logic       wb_fire;

    alu_issue_decode u_decode (
        .instr   (in_instr),
        .rs1_val (in_rs1_val),
        .rs2_val (in_rs2_val),
        .dec     (dec)
    );

    // Gated by rst so upstream never sees ready while the unit is held.
    assign in_ready = (state == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign wb_fire  = wb_valid && wb_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ALUop1    <= '0;
            ALUop2    <= '0;
            ALUfunc3  <= '0;
            ALUsubsra <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_err    <= 1'b0;
            retired   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wb_rd <= dec.rd;
                        if (dec.illegal) begin
                            // Skip EXEC: report the error straight away.
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_data  <= '0;
                            state    <= ST_WB;
                        end else begin
                            ALUop1    <= dec.op1;
                            ALUop2    <= dec.op2;
                            ALUfunc3  <= dec.func3;
                            ALUsubsra <= dec.subsra;
                            wb_err    <= 1'b0;
                            state     <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // x0 is hardwired to zero; the op still runs on the ALU.
                    wb_data  <= (wb_rd == 5'd0) ? 32'd0 : ALUresult;
                    wb_valid <= 1'b1;
                    state    <= ST_WB;
                end
                ST_WB: begin
                    // Payload registers are untouched here, so they hold
                    // steady under backpressure.
                    if (wb_fire) begin
                        wb_valid <= 1'b0;
                        retired  <= retired + CNT_W'(1);
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
